// File: rtl/tt_um_rodschz_adder04.sv
// Four-bit arithmetic unit with a registered result and registered status flags.
// Operands a = ui_in[7:4] and b = ui_in[3:0]; uio_in[1:0] selects ADD, SUB,
// MUL or ACC (accumulate a+b into an internal 8-bit register).
// Flags are presented on uio_out[7:4] as {zero, carry, negative, wrap}.
module tt_um_rodschz_adder04 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ACC = 2'b11
    } op_t;

    op_t        op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum5;
    logic [7:0] diff8;
    logic [7:0] prod8;
    logic [8:0] acc_sum9;

    logic [7:0] result_reg;
    logic [3:0] flags_reg;
    logic [7:0] acc_reg;

    logic [7:0] result_next;
    logic [7:0] acc_next;
    logic       negative_next;
    logic       wrap_next;

    // Upper select bits are reserved and intentionally ignored.
    logic       unused_sel_bits;

    assign unused_sel_bits = &{1'b0, uio_in[7:2]};

    assign op       = op_t'(uio_in[1:0]);
    assign a        = ui_in[7:4];
    assign b        = ui_in[3:0];
    assign sum5     = {1'b0, a} + {1'b0, b};
    assign diff8    = {4'b0000, a} - {4'b0000, b};
    assign prod8    = {4'b0000, a} * {4'b0000, b};
    assign acc_sum9 = {1'b0, acc_reg} + {4'b0000, sum5};

    // Select the result for the current op; accumulator only moves in ACC.
    always_comb begin
        result_next   = 8'h00;
        acc_next      = acc_reg;
        negative_next = 1'b0;
        wrap_next     = 1'b0;
        case (op)
            OP_ADD: begin
                result_next = {3'b000, sum5};
            end
            OP_SUB: begin
                result_next   = diff8;
                negative_next = (a < b);
            end
            OP_MUL: begin
                result_next = prod8;
            end
            OP_ACC: begin
                result_next = acc_sum9[7:0];
                acc_next    = acc_sum9[7:0];
                wrap_next   = acc_sum9[8];
            end
            default: begin
                result_next = 8'h00;
            end
        endcase
    end

    // Result, flags and accumulator update together; reset beats enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= 8'h00;
            flags_reg  <= 4'h0;
            acc_reg    <= 8'h00;
        end else if (ena) begin
            result_reg <= result_next;
            flags_reg  <= {(result_next == 8'h00), sum5[4], negative_next, wrap_next};
            acc_reg    <= acc_next;
        end
    end

    assign uo_out  = result_reg;
    assign uio_out = {flags_reg, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_rodschz_adder04.sv
// Self-checking bench for tt_um_rodschz_adder04: directed vector table,
// hand-written accumulate/reset sequences and randomized model comparison.
module tb_tt_um_rodschz_adder04;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    // Reference state: plain integers computed from the operation rules.
    int m_out;
    int m_flags;
    int m_acc;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [7:0] uio;
        logic [7:0] ui;
        logic [7:0] exp_out;
        logic [3:0] exp_flags;
        string      name;
    } vec_t;

    vec_t vecs[14];

    tt_um_rodschz_adder04 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelStep(input logic r, input logic e, input logic [1:0] op, input logic [7:0] ui);
        int a;
        int b;
        int s;
        int res;
        int zero;
        int carry;
        int neg;
        int wrap;
        a = int'(ui[7:4]);
        b = int'(ui[3:0]);
        s = a + b;
        if (!r) begin
            m_out   = 0;
            m_flags = 0;
            m_acc   = 0;
        end else if (e) begin
            neg  = 0;
            wrap = 0;
            res  = 0;
            case (op)
                2'd0: res = s;
                2'd1: begin
                    res = (a - b) & 255;
                    neg = (a < b) ? 1 : 0;
                end
                2'd2: res = a * b;
                default: begin
                    wrap  = ((m_acc + s) > 255) ? 1 : 0;
                    res   = (m_acc + s) % 256;
                    m_acc = res;
                end
            endcase
            zero    = (res == 0) ? 1 : 0;
            carry   = (s > 15) ? 1 : 0;
            m_out   = res;
            m_flags = zero * 8 + carry * 4 + neg * 2 + wrap;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] uio, input logic [7:0] ui);
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        uio_in = uio;
        ui_in  = ui;
        @(posedge clk);
        #1;
        modelStep(r, e, uio[1:0], ui);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_out, input logic [3:0] exp_flags);
        checks++;
        if (uo_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL %s uo_out got %02h expected %02h", name, uo_out, exp_out);
        end
        checks++;
        if (uio_out !== {exp_flags, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL %s uio_out got %02h expected %02h", name, uio_out, {exp_flags, 4'b0000});
        end
        checks++;
        if (uio_oe !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL %s uio_oe got %02h expected f0", name, uio_oe);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_out  = 0;
        m_flags = 0;
        m_acc  = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // rst_n, ena, uio_in, ui_in, expected uo_out, expected flags {Z,C,N,W}
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, "reset_no_ena"};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 8'h35, 8'h08, 4'b0000, "add_35"};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h1E, 4'b0100, "add_ff_carry"};
        vecs[3]  = '{1'b1, 1'b1, 8'h01, 8'h25, 8'hFD, 4'b0010, "sub_25_neg"};
        vecs[4]  = '{1'b1, 1'b1, 8'h01, 8'h77, 8'h00, 4'b1000, "sub_77_zero"};
        vecs[5]  = '{1'b1, 1'b1, 8'h02, 8'hFF, 8'hE1, 4'b0100, "mul_ff"};
        vecs[6]  = '{1'b1, 1'b1, 8'hFC, 8'h12, 8'h03, 4'b0000, "add_high_sel_ignored"};
        vecs[7]  = '{1'b1, 1'b0, 8'h02, 8'hFF, 8'h03, 4'b0000, "hold_mul"};
        vecs[8]  = '{1'b1, 1'b0, 8'h03, 8'h34, 8'h03, 4'b0000, "hold_acc"};
        vecs[9]  = '{1'b1, 1'b1, 8'h02, 8'h34, 8'h0C, 4'b0000, "mul_after_hold"};
        vecs[10] = '{1'b1, 1'b0, 8'h03, 8'hFF, 8'h0C, 4'b0000, "hold_acc_ff"};
        vecs[11] = '{1'b1, 1'b1, 8'h03, 8'h11, 8'h02, 4'b0000, "acc_after_hold"};
        vecs[12] = '{1'b0, 1'b1, 8'h03, 8'hFF, 8'h00, 4'b0000, "reset_with_ena"};
        vecs[13] = '{1'b1, 1'b1, 8'h03, 8'h00, 8'h00, 4'b1000, "acc_zero_after_reset"};

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].ena, vecs[i].uio, vecs[i].ui);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_flags);
        end

        $display("[TB] accumulate sequence with wrap");
        applyStimulus(1'b0, 1'b1, 8'h03, 8'hFF);
        checkOutput("acc_seq_reset", 8'h00, 4'b0000);
        applyStimulus(1'b1, 1'b0, 8'h03, 8'hFF);
        checkOutput("zero_flag_low_after_reset", 8'h00, 4'b0000);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 1'b1, 8'h03, 8'hFF);
            checkOutput($sformatf("acc_step_%0d", k), 8'((30 * k) % 256),
                        (k == 9) ? 4'b0101 : 4'b0100);
        end

        $display("[TB] reset in the middle of accumulation");
        applyStimulus(1'b0, 1'b1, 8'h03, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b1, 8'h03, 8'hFF);
        end
        checkOutput("acc_to_90", 8'd90, 4'b0100);
        applyStimulus(1'b0, 1'b1, 8'h03, 8'hFF);
        checkOutput("mid_acc_reset", 8'h00, 4'b0000);
        applyStimulus(1'b1, 1'b1, 8'h03, 8'h11);
        checkOutput("acc_from_zero", 8'h02, 4'b0000);

        $display("[TB] randomized stimulus against model");
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       e;
            logic [7:0] uio;
            logic [7:0] ui;
            r   = ($urandom_range(0, 31) != 0);
            e   = ($urandom_range(0, 7) != 0);
            uio = 8'($urandom);
            ui  = 8'($urandom);
            applyStimulus(r, e, uio, ui);
            checkOutput($sformatf("rand_%0d", i), 8'(m_out), 4'(m_flags));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
